mux_nx1_stream: RTL

Parametrised N-input, W-bit registered stream multiplexer with valid/ready handshake on every channel. It generalises the 2:1 combinational select into a clocked datapath block. It supports two modes: manual channel select, and fair round-robin arbitration. It sits between multiple producers and a single consumer, with one output register stage.

---
 rtl/mux_nx1_stream_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 61 ++++++
 rtl/mux_nx1_stream.sv | 103 ++++++++++
 3 files changed

// File: rtl/mux_nx1_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_nx1_stream_pkg
// Description : Shared constants and helpers for the N:1 stream multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_nx1_stream_pkg;

    // Values of the mode input
    localparam logic C_MODE_MANUAL = 1'b0;
    localparam logic C_MODE_RR     = 1'b1;

    // Ceiling log2 usable in parameter context; the loop bound keeps the shift
    // inside the positive range of int.
    function automatic int mux_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 30; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter. Holds the priority pointer and finds the
//               first requester starting at the pointer, with wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import mux_nx1_stream_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = mux_clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            advance,
    output logic            gnt_valid,
    output logic [SELW-1:0] gnt_idx
);

    logic [SELW-1:0] r_ptr;
    int              w_next_ptr;

    // Wrap-around search: ptr, ptr+1, ..., N-1, 0, ..., ptr-1
    always_comb begin
        int cand;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(r_ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SELW'(cand);
            end
        end
    end

    // Pointer moves to the channel just after the one granted, modulo N
    always_comb begin
        w_next_ptr = int'(gnt_idx) + 1;
        if (w_next_ptr >= N) begin
            w_next_ptr = 0;
        end
    end

    // Pointer register; only advances on an accepted round-robin transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (advance && gnt_valid) begin
            r_ptr <= SELW'(w_next_ptr);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_nx1_stream.sv
`default_nettype none
// ============================================================================
// Module      : mux_nx1_stream
// Description : N-input, W-bit registered stream multiplexer with valid/ready
//               on every channel. Manual select or round-robin arbitration,
//               one output register stage, 1 word/cycle sustained.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_nx1_stream
    import mux_nx1_stream_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int W    = 8,
    localparam int SELW = mux_clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    in_valid,
    input  logic [N*W-1:0]  in_data,
    output logic [N-1:0]    in_ready,
    input  logic [SELW-1:0] sel,
    input  logic            mode,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    input  logic            out_ready,
    output logic [SELW-1:0] grant_idx
);

    logic            w_arb_valid;
    logic [SELW-1:0] w_arb_idx;
    logic            w_man_valid;
    logic            w_win_valid;
    logic [SELW-1:0] w_winner;
    logic            w_load_en;
    logic            w_take;
    logic            w_rr_advance;

    logic            r_out_valid;
    logic [W-1:0]    r_out_data;
    logic [SELW-1:0] r_grant_idx;

    rr_arbiter #(
        .N (N)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst       (rst),
        .req       (in_valid),
        .advance   (w_rr_advance),
        .gnt_valid (w_arb_valid),
        .gnt_idx   (w_arb_idx)
    );

    // Manual winner: an out-of-range select never wins
    always_comb begin
        w_man_valid = 1'b0;
        if (int'(sel) < N) begin
            w_man_valid = in_valid[sel];
        end
    end

    // Mode mux; a mode or sel change is seen by the same-cycle winner
    always_comb begin
        if (mode == C_MODE_RR) begin
            w_win_valid = w_arb_valid;
            w_winner    = w_arb_idx;
        end else begin
            w_win_valid = w_man_valid;
            w_winner    = sel;
        end
    end

    // Handshake: accept when the register is empty or draining this cycle
    always_comb begin
        w_load_en    = !r_out_valid || out_ready;
        w_take       = !rst && w_load_en && w_win_valid;
        w_rr_advance = w_take && (mode == C_MODE_RR);
        in_ready     = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = w_take && (w_winner == SELW'(i));
        end
    end

    // Output register: load on transfer, clear valid on drain, else hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_grant_idx <= '0;
        end else if (w_take) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data[int'(w_winner)*W +: W];
            r_grant_idx <= w_winner;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign grant_idx = r_grant_idx;

endmodule
`default_nettype wire
